// File: rtl/reg_cmd_ctrl_if.sv
// Bus bundle for reg_cmd_ctrl: UART RX byte stream in, register file
// Address/WrData/WrEn/RdEn out with RdData back, UART TX byte handshake out.
// master = the command controller, slave = the surrounding RX/regfile/TX blocks.
interface reg_cmd_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int ADDR  = 4
);
    logic [WIDTH-1:0] RX_P_DATA;
    logic             RX_D_VLD;
    logic [ADDR-1:0]  Address;
    logic [WIDTH-1:0] WrData;
    logic             WrEn;
    logic             RdEn;
    logic [WIDTH-1:0] RdData;
    logic             RdData_valid;
    logic [WIDTH-1:0] TX_P_DATA;
    logic             TX_D_VLD;
    logic             TX_BUSY;

    modport master (
        input  RX_P_DATA, RX_D_VLD, RdData, RdData_valid, TX_BUSY,
        output Address, WrData, WrEn, RdEn, TX_P_DATA, TX_D_VLD
    );

    modport slave (
        output RX_P_DATA, RX_D_VLD, RdData, RdData_valid, TX_BUSY,
        input  Address, WrData, WrEn, RdEn, TX_P_DATA, TX_D_VLD
    );
endinterface

// File: rtl/reg_cmd_ctrl.sv
// Command controller between the UART RX deframer and the register file.
// Decodes {CMD_WR, addr, data} and {CMD_RD, addr} frames, drives the
// register file, and returns read data to the UART TX serializer.
// Optional feature macro CMD_ERR_EN: when defined, unknown opcodes and
// out-of-range write addresses are answered with an 8'hEE byte on TX.
// All outputs are registered; reset is asynchronous, active low.
module reg_cmd_ctrl #(
    parameter int               WIDTH  = 8,
    parameter int               ADDR   = 4,
    parameter int               DEPTH  = 8,
    parameter logic [WIDTH-1:0] CMD_WR = 8'hAA,
    parameter logic [WIDTH-1:0] CMD_RD = 8'hBB
) (
    input logic            clk,
    input logic            rst,
    reg_cmd_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_REQ, RD_WAIT, TX_SEND
    } state_t;

    localparam logic [ADDR:0] DEPTH_C = (ADDR+1)'(DEPTH);
`ifdef CMD_ERR_EN
    localparam logic [WIDTH-1:0] ERR_BYTE = WIDTH'(8'hEE);
`endif

    state_t           state_q, state_d;
    logic [ADDR-1:0]  addr_q, addr_d;
    logic [ADDR-1:0]  address_q, address_d;
    logic [WIDTH-1:0] wr_data_q, wr_data_d;
    logic             wr_en_q, wr_en_d;
    logic             rd_en_q, rd_en_d;
    logic [WIDTH-1:0] tx_data_q, tx_data_d;
    logic             tx_vld_q, tx_vld_d;

    logic [ADDR-1:0]  rx_addr;
    assign rx_addr = bus.RX_P_DATA[ADDR-1:0];

    function automatic logic in_range(input logic [ADDR-1:0] a);
        return {1'b0, a} < DEPTH_C;
    endfunction

    // Frame decoder: next state plus next values of every registered output.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_d   = state_q;
        addr_d    = addr_q;
        address_d = address_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        tx_data_d = tx_data_q;
        tx_vld_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.RX_D_VLD) begin
                    if (bus.RX_P_DATA == CMD_WR) begin
                        state_d = WR_ADDR;
                    end else if (bus.RX_P_DATA == CMD_RD) begin
                        state_d = RD_ADDR;
                    end else begin
`ifdef CMD_ERR_EN
                        tx_data_d = ERR_BYTE;
                        state_d   = TX_SEND;
`else
                        state_d   = IDLE;
`endif
                    end
                end
            end
            WR_ADDR: begin
                if (bus.RX_D_VLD) begin
                    addr_d  = rx_addr;
                    state_d = WR_DATA;
                end
            end
            WR_DATA: begin
                if (bus.RX_D_VLD) begin
                    if (in_range(addr_q)) begin
                        address_d = addr_q;
                        wr_data_d = bus.RX_P_DATA;
                        wr_en_d   = 1'b1;
                        state_d   = IDLE;
                    end else begin
`ifdef CMD_ERR_EN
                        tx_data_d = ERR_BYTE;
                        state_d   = TX_SEND;
`else
                        state_d   = IDLE;
`endif
                    end
                end
            end
            RD_ADDR: begin
                if (bus.RX_D_VLD) begin
                    addr_d = rx_addr;
                    if (in_range(rx_addr)) begin
                        address_d = rx_addr;
                        rd_en_d   = 1'b1;
                        state_d   = RD_REQ;
                    end else begin
                        // Out-of-range reads answer zero in both builds.
                        tx_data_d = '0;
                        state_d   = TX_SEND;
                    end
                end
            end
            // Register file samples RdEn on the edge leaving this state.
            RD_REQ: state_d = RD_WAIT;
            RD_WAIT: begin
                if (bus.RdData_valid) begin
                    tx_data_d = bus.RdData;
                    state_d   = TX_SEND;
                end
            end
            TX_SEND: begin
                if (!bus.TX_BUSY) begin
                    tx_vld_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any partial frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            address_q <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            tx_data_q <= '0;
            tx_vld_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            addr_q    <= addr_d;
            address_q <= address_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            tx_data_q <= tx_data_d;
            tx_vld_q  <= tx_vld_d;
        end
    end

    assign bus.Address   = address_q;
    assign bus.WrData    = wr_data_q;
    assign bus.WrEn      = wr_en_q;
    assign bus.RdEn      = rd_en_q;
    assign bus.TX_P_DATA = tx_data_q;
    assign bus.TX_D_VLD  = tx_vld_q;
endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// Self-checking bench for reg_cmd_ctrl: directed frames plus randomized
// frames checked against a frame-level reference model (expected write,
// read and TX queues kept over a model register array).
module tb_reg_cmd_ctrl;
    localparam int         WIDTH  = 8;
    localparam int         ADDR   = 4;
    localparam int         DEPTH  = 8;
    localparam logic [7:0] CMD_WR = 8'hAA;
    localparam logic [7:0] CMD_RD = 8'hBB;
`ifdef CMD_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    reg_cmd_ctrl_if #(.WIDTH(WIDTH), .ADDR(ADDR)) bus ();

    reg_cmd_ctrl #(
        .WIDTH(WIDTH), .ADDR(ADDR), .DEPTH(DEPTH), .CMD_WR(CMD_WR), .CMD_RD(CMD_RD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Stimulus-side drivers
    logic [7:0] rx_data = 8'h00;
    logic       rx_vld  = 1'b0;
    logic       tx_busy = 1'b0;
    logic       busy_rand = 1'b0;
    assign bus.RX_P_DATA = rx_data;
    assign bus.RX_D_VLD  = rx_vld;
    assign bus.TX_BUSY   = tx_busy;

    // Register file stand-in: read data returned one cycle after RdEn
    logic [7:0] rf_mem [16] = '{2: 8'h81, 3: 8'h20, default: 8'h00};
    logic [7:0] rf_rdata = 8'h00;
    logic       rf_valid = 1'b0;
    assign bus.RdData       = rf_rdata;
    assign bus.RdData_valid = rf_valid;
    always @(posedge clk) begin
        rf_valid <= bus.RdEn;
        if (bus.RdEn) rf_rdata <= rf_mem[bus.Address];
        if (bus.WrEn) rf_mem[bus.Address] <= bus.WrData;
    end

    // Checking
    int n_cmp = 0;
    int n_err = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: frame-level expectations
    typedef struct packed { logic [3:0] a; logic [7:0] d; } wr_t;
    wr_t        exp_wr[$];
    logic [3:0] exp_rd[$];
    logic [7:0] exp_tx[$];
    logic [7:0] mdl_mem [16] = '{2: 8'h81, 3: 8'h20, default: 8'h00};
    int         mdl_addr = 0;

    task automatic model(input logic [7:0] op, input logic [7:0] abyte, input logic [7:0] d);
        int a;
        a = int'(abyte) % 16;
        if (op == CMD_WR) begin
            if (a < DEPTH) begin
                exp_wr.push_back({4'(a), d});
                mdl_mem[a] = d;
                mdl_addr = a;
            end else if (ERR_EN) begin
                exp_tx.push_back(8'hEE);
            end
        end else if (op == CMD_RD) begin
            if (a < DEPTH) begin
                exp_rd.push_back(4'(a));
                exp_tx.push_back(mdl_mem[a]);
                mdl_addr = a;
            end else begin
                exp_tx.push_back(8'h00);
            end
        end else if (ERR_EN) begin
            exp_tx.push_back(8'hEE);
        end
    endtask

    // Monitor: every output event is matched against the model queues
    int   cyc = 0;
    int   last_rd_cyc = -1;
    int   last_tx_cyc = -1;
    logic vld_at_edge = 1'b0;
    logic busy_at_edge = 1'b0;
    always @(posedge clk) begin
        cyc          <= cyc + 1;
        vld_at_edge  <= rx_vld;
        busy_at_edge <= tx_busy;
    end

    always @(negedge clk) begin
        wr_t w;
        if (rst) begin
            if (bus.WrEn || bus.RdEn) check("wr_rd_excl", 32'(bus.WrEn & bus.RdEn), 0);
            if (bus.WrEn) begin
                if (exp_wr.size() == 0) check("wr_unexpected", 1, 0);
                else begin
                    w = exp_wr.pop_front();
                    check("wr_addr", 32'(bus.Address), 32'(w.a));
                    check("wr_data", 32'(bus.WrData), 32'(w.d));
                    check("wr_latency", 32'(vld_at_edge), 1);
                end
            end
            if (bus.RdEn) begin
                last_rd_cyc = cyc;
                if (exp_rd.size() == 0) check("rd_unexpected", 1, 0);
                else begin
                    check("rd_addr", 32'(bus.Address), 32'(exp_rd.pop_front()));
                    check("rd_latency", 32'(vld_at_edge), 1);
                end
            end
            if (bus.TX_D_VLD) begin
                last_tx_cyc = cyc;
                check("tx_while_busy", 32'(busy_at_edge), 0);
                if (exp_tx.size() == 0) check("tx_unexpected", 1, 0);
                else check("tx_data", 32'(bus.TX_P_DATA), 32'(exp_tx.pop_front()));
            end
        end
    end

    // Random TX_BUSY during the random phase
    always @(posedge clk) begin
        #1;
        if (busy_rand) tx_busy = ($urandom_range(0, 2) == 0);
    end

    // Drives up to 8 bytes as RX strobes, with gap idle cycles between them
    task automatic send(input logic [7:0] bs [8], input int n, input int gap);
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            rx_data = bs[i];
            rx_vld  = 1'b1;
            @(posedge clk); #1;
            if (gap > 0 && i < n - 1) begin
                rx_vld = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
        end
        rx_vld = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_wr.size() + exp_rd.size() + exp_tx.size()) != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        @(negedge clk);
        check("drain", 32'(exp_wr.size() + exp_rd.size() + exp_tx.size()), 0);
    endtask

    task automatic frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] d, input int gap);
        model(op, a, d);
        if (op == CMD_WR)      send('{op, a, d, 0, 0, 0, 0, 0}, 3, gap);
        else if (op == CMD_RD) send('{op, a, 0, 0, 0, 0, 0, 0}, 2, gap);
        else                   send('{op, 0, 0, 0, 0, 0, 0, 0}, 1, gap);
        drain();
        check("addr_hold", 32'(bus.Address), 32'(mdl_addr));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_addr"},  32'(bus.Address), 0);
        check({tag, "_wdata"}, 32'(bus.WrData), 0);
        check({tag, "_wren"},  32'(bus.WrEn), 0);
        check({tag, "_rden"},  32'(bus.RdEn), 0);
        check({tag, "_txd"},   32'(bus.TX_P_DATA), 0);
        check({tag, "_txv"},   32'(bus.TX_D_VLD), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fall_cyc;
        logic [7:0] op, a, d;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_outputs_zero("post_reset");

        // Reads at reset defaults
        frame(CMD_RD, 8'h03, 0, 0);
        frame(CMD_RD, 8'h02, 0, 0);

        // Write then read back, with read pipeline latency
        frame(CMD_WR, 8'h02, 8'h5C, 0);
        frame(CMD_RD, 8'h02, 0, 0);
        check("rd_to_tx", 32'(last_tx_cyc - last_rd_cyc), 3);

        // TX_BUSY held high: TX waits, RX bytes in that window are dropped
        model(CMD_RD, 8'h02, 0);
        tx_busy = 1'b1;
        send('{CMD_RD, 8'h02, 0, 0, 0, 0, 0, 0}, 2, 0);
        repeat (4) @(posedge clk);
        send('{CMD_WR, 8'h00, 8'h77, 0, 0, 0, 0, 0}, 3, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("tx_held", 32'(exp_tx.size()), 1);
        @(posedge clk); #1;
        tx_busy  = 1'b0;
        fall_cyc = cyc;
        drain();
        check("tx_after_busy", 32'(last_tx_cyc - fall_cyc), 1);
        frame(CMD_RD, 8'h00, 0, 0);

        // Out of range write and read
        frame(CMD_WR, 8'h09, 8'hFF, 0);
        frame(CMD_RD, 8'h09, 0, 0);

        // Unknown opcode followed by a write
        frame(8'h3C, 0, 0, 0);
        frame(CMD_WR, 8'h01, 8'h11, 0);
        frame(CMD_RD, 8'h01, 0, 0);

        // Back-to-back frames with no idle cycles between strobes
        model(CMD_WR, 8'h05, 8'hA5);
        model(CMD_WR, 8'h06, 8'h6B);
        model(CMD_RD, 8'h05, 0);
        send('{CMD_WR, 8'h05, 8'hA5, CMD_WR, 8'h06, 8'h6B, CMD_RD, 8'h05}, 8, 0);
        drain();

        // Reset mid-frame aborts the partial write
        send('{CMD_WR, 8'h04, 0, 0, 0, 0, 0, 0}, 2, 0);
        rst = 1'b0;
        mdl_addr = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("mid_reset");
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("after_abort");
        frame(CMD_WR, 8'h04, 8'h3E, 0);
        frame(CMD_RD, 8'h04, 0, 0);

        // Randomized frames with random gaps and random TX_BUSY
        busy_rand = 1'b1;
        for (int i = 0; i < 60; i++) begin
            int k;
            k = $urandom_range(0, 9);
            a = 8'($urandom);
            if ($urandom_range(0, 3) != 0) a[3] = 1'b0;
            d = 8'($urandom);
            if (k < 4)      op = CMD_WR;
            else if (k < 8) op = CMD_RD;
            else begin
                op = 8'($urandom);
                while (op == CMD_WR || op == CMD_RD) op = 8'($urandom);
            end
            frame(op, a, d, $urandom_range(0, 2));
        end
        busy_rand = 1'b0;
        @(posedge clk); #2;
        tx_busy = 1'b0;

        // Every model register read back
        for (int r = 0; r < DEPTH; r++) frame(CMD_RD, 8'(r), 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
